// File: rtl/seed_key_round_ctrl.sv
// SEED key-schedule round controller: walks the A..D / KC rotations and emits the
// per-round pre-G operands t0 = A+C-KC and t1 = B-D+KC over a valid/ready handshake.
module seed_key_round_ctrl #(
    parameter int unsigned NUM_ROUNDS = 16,
    parameter logic [31:0] KC_INIT    = 32'h9E3779B9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   round_idx,
    output logic [31:0]  t0,
    output logic [31:0]  t1,
    output logic         done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OUT,
        ST_DONE
    } state_e;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    state_e      state_q;
    logic [31:0] a_q, b_q, c_q, d_q, kc_q;
    logic [31:0] a_d, b_d, c_d, d_d, kc_d;
    logic [3:0]  round_q, round_d;
    logic [31:0] t0_q, t1_q;
    logic        busy_q, valid_q, done_q;
    logic        load, advance;

    assign load    = (state_q == ST_IDLE) && start;
    assign advance = (state_q == ST_OUT) && out_ready && (round_q != LAST_ROUND);

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        kc_d    = kc_q;
        round_d = round_q;
        if (load) begin
            {a_d, b_d, c_d, d_d} = key_in;
            kc_d    = KC_INIT;
            round_d = '0;
        end else if (advance) begin
            if (!round_q[0]) begin
                {a_d, b_d} = {b_q[7:0], a_q, b_q[31:8]};   // (A||B) rotr 8
            end else begin
                {c_d, d_d} = {c_q[23:0], d_q, c_q[31:24]}; // (C||D) rotl 8
            end
            kc_d    = {kc_q[30:0], kc_q[31]};
            round_d = round_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            kc_q    <= '0;
            round_q <= '0;
            t0_q    <= '0;
            t1_q    <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            kc_q    <= kc_d;
            round_q <= round_d;
            // Built from next-state values so the operands line up with out_valid.
            t0_q    <= a_d + c_d - kc_d;
            t1_q    <= b_d - d_d + kc_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_OUT;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready && (round_q == LAST_ROUND)) begin
                        state_q <= ST_DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign round_idx = round_q;
    assign t0        = t0_q;
    assign t1        = t1_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seed_key_round_ctrl.sv
// Self-checking bench for seed_key_round_ctrl: scoreboarded round words, stalls,
// ignored restarts, mid-schedule reset and a two-round instance.
module tb_seed_key_round_ctrl;

    typedef struct packed {
        logic [3:0]  rnd;
        logic [31:0] t0;
        logic [31:0] t1;
    } word_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, out_ready;
    logic [127:0] key_in;
    logic         busy, out_valid, done;
    logic [3:0]   round_idx;
    logic [31:0]  t0, t1;

    logic         start2, out_ready2;
    logic [127:0] key_in2;
    logic         busy2, out_valid2, done2;
    logic [3:0]   round_idx2;
    logic [31:0]  t0_2, t1_2;

    int    n_vec = 0;
    int    n_err = 0;
    int    done_cnt = 0;
    word_t exp_q[$];

    always #5 clk = ~clk;

    seed_key_round_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .round_idx(round_idx),
        .t0(t0), .t1(t1), .done(done)
    );

    seed_key_round_ctrl #(.NUM_ROUNDS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .key_in(key_in2), .busy(busy2),
        .out_valid(out_valid2), .out_ready(out_ready2), .round_idx(round_idx2),
        .t0(t0_2), .t1(t1_2), .done(done2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference SEED key schedule: expected round words for one key.
    task automatic push_schedule(input logic [127:0] key, input int n);
        logic [31:0] a, b, c, d, kc;
        word_t w;
        {a, b, c, d} = key;
        kc = 32'h9E3779B9;
        for (int r = 0; r < n; r++) begin
            w.rnd = 4'(r);
            w.t0  = a + c - kc;
            w.t1  = b - d + kc;
            exp_q.push_back(w);
            if (r % 2 == 0) {a, b} = {{a, b}, {a, b}} >> 8;
            else            {c, d} = {{c, d}, {c, d}} >> 56;
            kc = {kc[30:0], kc[31]};
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    logic        stall_prev = 1'b0, done_prev = 1'b0;
    logic [3:0]  rnd_prev;
    logic [31:0] t0_prev, t1_prev;
    always @(negedge clk) begin
        word_t e;
        if (rst) begin
            stall_prev = 1'b0;
            done_prev  = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall valid held", out_valid, 1);
                check("stall round held", round_idx, rnd_prev);
                check("stall t0 held", t0, t0_prev);
                check("stall t1 held", t1, t1_prev);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("word round_idx", round_idx, e.rnd);
                    check("word t0", t0, e.t0);
                    check("word t1", t1, e.t1);
                end
            end
            if (done) begin
                done_cnt++;
                check("done with words pending", exp_q.size(), 0);
                if (done_prev) check("done one cycle", 1, 0);
            end
            stall_prev = out_valid && !out_ready;
            done_prev  = done;
            rnd_prev   = round_idx;
            t0_prev    = t0;
            t1_prev    = t1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sched(input logic [127:0] key, input logic [127:0] alt_key,
                             input bit rnd_ready, input int restart_rnd);
        int cyc;
        bit restarted;
        push_schedule(key, 16);
        key_in = key;
        start  = 1'b1;
        step();
        start     = 1'b0;
        cyc       = 0;
        restarted = 1'b0;
        while (!done && cyc < 400) begin
            if (restart_rnd >= 0 && !restarted && out_valid && round_idx == 4'(restart_rnd)) begin
                key_in    = alt_key;
                start     = 1'b1;
                restarted = 1'b1;
            end
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            step();
            start = 1'b0;
            cyc++;
        end
        check("done reached", done, 1);
        out_ready = 1'b1;
        step();
        check("done cleared", done, 0);
        check("busy cleared", busy, 0);
        check("scoreboard drained", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int done_snap;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; key_in = '0;
        start2 = 1'b0; out_ready2 = 1'b0; key_in2 = '0;
        step();
        step();
        check("rst busy", busy, 0);
        check("rst out_valid", out_valid, 0);
        check("rst done", done, 0);
        check("rst round_idx", round_idx, 0);
        check("rst t0", t0, 0);
        check("rst t1", t1, 0);
        check("rst dut2 valid", out_valid2, 0);
        rst = 1'b0;
        step();

        // Zero key, ready held high: one word per clock then a single done.
        out_ready = 1'b1;
        push_schedule('0, 16);
        key_in = '0;
        start  = 1'b1;
        step();
        start = 1'b0;
        check("k0 first valid", out_valid, 1);
        check("k0 busy", busy, 1);
        check("k0 r0 t0", t0, 32'h61C88647);
        check("k0 r0 t1", t1, 32'h9E3779B9);
        step();
        cyc = 1;
        check("k0 r1 t0", t0, 32'hC3910C8D);
        check("k0 r1 t1", t1, 32'h3C6EF373);
        while (!done && cyc < 100) begin
            step();
            cyc++;
            if (!done) check("k0 busy during run", busy, 1);
        end
        check("k0 done latency", cyc, 16);
        check("k0 busy with done", busy, 1);
        step();
        check("k0 done pulse width", done, 0);
        check("k0 busy after done", busy, 0);
        check("k0 valid after done", out_valid, 0);
        check("k0 scoreboard drained", exp_q.size(), 0);

        // Counting-byte key: first word checked directly, the rest by scoreboard.
        key_in = 128'h00010203_04050607_08090A0B_0C0D0E0F;
        push_schedule(key_in, 16);
        start = 1'b1;
        step();
        start = 1'b0;
        check("kc r0 t0", t0, 32'h69D29255);
        check("kc r0 t1", t1, 32'h962F71B1);
        cyc = 0;
        while (!done && cyc < 100) begin
            step();
            cyc++;
        end
        check("kc done reached", done, 1);
        step();
        check("kc scoreboard drained", exp_q.size(), 0);

        // Random backpressure.
        run_sched({$urandom, $urandom, $urandom, $urandom}, '0, 1'b1, -1);
        run_sched(128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978, '0, 1'b1, -1);

        // Second start at round 5 must be ignored.
        run_sched(128'h11111111_22222222_33333333_44444444,
                  128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 1'b0, 5);

        // Reset mid-schedule at round 7.
        push_schedule(128'h0BADF00D_DEADBEEF_CAFEBABE_12345678, 16);
        key_in = 128'h0BADF00D_DEADBEEF_CAFEBABE_12345678;
        start  = 1'b1;
        step();
        start = 1'b0;
        cyc   = 0;
        while (!(out_valid && round_idx == 4'd7) && cyc < 40) begin
            step();
            cyc++;
        end
        check("reached round 7", round_idx, 7);
        done_snap = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        check("arst valid", out_valid, 0);
        check("arst busy", busy, 0);
        check("arst round_idx", round_idx, 0);
        check("arst t0", t0, 0);
        check("arst t1", t1, 0);
        exp_q.delete();
        step();
        rst = 1'b0;
        repeat (4) step();
        check("no done after reset", done_cnt, done_snap);
        check("idle after reset", busy, 0);
        run_sched(128'h0BADF00D_DEADBEEF_CAFEBABE_12345678, '0, 1'b0, -1);

        // Two-round instance.
        out_ready2 = 1'b1;
        key_in2    = '0;
        start2     = 1'b1;
        step();
        start2 = 1'b0;
        check("n2 r0 valid", out_valid2, 1);
        check("n2 r0 round", round_idx2, 0);
        check("n2 r0 kc", t1_2, 32'h9E3779B9);
        check("n2 r0 t0", t0_2, 32'h61C88647);
        step();
        check("n2 r1 round", round_idx2, 1);
        check("n2 r1 kc", t1_2, 32'h3C6EF373);
        step();
        check("n2 done", done2, 1);
        check("n2 valid dropped", out_valid2, 0);
        step();
        check("n2 done cleared", done2, 0);
        check("n2 busy cleared", busy2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
